pipe_sink_fifo: RTL and testbench
=================================

Name: pipe_sink_fifo

Overview:
Receiving end of the valid/allowin stallable-pipeline handshake. It absorbs the final stage's valid/data, generates the allowin backpressure for that stage, and buffers items in a DEPTH-entry FIFO. A show-ahead read port lets a downstream consumer drain at its own rate. It sits directly after the last pipeline stage, with its in_allowin wired to that stage's out_allow.

Parameters:
WIDTH, 100, data width in bits
DEPTH, 4, FIFO entries; power of two, >= 2
AW, clog2(DEPTH), pointer width (derived, not overridden)

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  reset, asynchronous, active-high
flush  input  1  synchronous clear of all buffered items
in_valid  input  1  upstream item valid (pipeline validout)
in_data  input  WIDTH  upstream item data (pipeline dataout)
in_allowin  output  1  sink can accept this cycle (to pipeline out_allow)
rd_en  input  1  consumer pops head item this cycle
rd_valid  output  1  head item present
rd_data  output  WIDTH  head item data (show-ahead)
level  output  AW+1  current occupancy, 0..DEPTH

Behaviour:
- State: mem[DEPTH], wptr/rptr (AW bits, wrap modulo DEPTH), count (AW+1 bits).
- Reset (async, rst=1): wptr=rptr=0, count=0. So in_allowin=1, rd_valid=0, level=0. Mem contents are not reset. rd_data is don't-care while rd_valid=0.
- in_allowin = (count != DEPTH). It depends only on registered state, with no combinational path from rd_en or in_valid.
- Push: push = in_valid && in_allowin. At posedge, mem[wptr] <= in_data and wptr <= wptr+1.
- Pop: pop = rd_en && rd_valid. At posedge, rptr <= rptr+1. rd_en while empty is ignored, with no state change and no error.
- rd_valid = (count != 0). rd_data = mem[rptr], combinational read.
- count update: push&&!pop gives +1; pop&&!push gives -1; both or neither leaves it unchanged.
- Latency: an item accepted at edge N is visible on rd_valid/rd_data after edge N (one cycle).
- Full with rd_en=1: pop occurs. Push is blocked that cycle because in_allowin=0. in_allowin rises the next cycle, giving one bubble by design.
- Empty with push and rd_en in the same cycle: no pop. The item appears next cycle. There is no bypass.
- Pointer wrap: DEPTH is a power of two, so wrap is natural overflow. Full and empty are distinguished by count, never by pointer equality.
- flush=1 at posedge sets wptr=rptr=count=0 and overrides any push or pop in the same cycle. An upstream item offered during flush is discarded. Upstream must treat in_allowin as sampled normally; the item is lost by design.
- rst asserted mid-transfer: all items are discarded immediately (asynchronous). in_allowin=1 while rst is held.
- Data ordering is strict FIFO, with no reordering or duplication.

Optional Feature:
PIPE_SINK_STATS_EN
- Defined: adds output stat_accepted [31:0] and output stat_stall [31:0].
  - stat_accepted counts pushes.
  - stat_stall counts cycles with in_valid && !in_allowin.
  - Both saturate at 32'hFFFF_FFFF. Both are cleared by rst and by flush.
- Undefined: these ports and their counters do not exist, and there is no other behavioural change.

Decomposition:
- Shared package/header pipe_pkg:
  - clog2 constant function
  - default WIDTH=100
  - STAT_W=32 constant
- Sub-module pipe_sink_mem: a DEPTH x WIDTH register array with one synchronous write port and one asynchronous read port. The top holds only the pointers, count and handshake logic.

Test Plan:
- Reset mid-stream: push 3 items (DEPTH=4), assert rst asynchronously between edges -> immediately level=0, rd_valid=0, in_allowin=1; no old data is popped after release.
- Fill and backpressure: in_valid=1 with data 1,2,3,4,5 and rd_en=0 -> 1..4 accepted; level=4; in_allowin=0; item 5 is held by upstream. Then rd_en=1 for one cycle -> pops 1; next cycle in_allowin=1 and 5 is accepted.
- Simultaneous push/pop at steady state: level=2, continuous in_valid and rd_en for 10 cycles -> level stays 2 and the output sequence is in order with no gaps.
- Empty corner: level=0, push A with rd_en=1 in the same cycle -> no pop; next cycle rd_valid=1, rd_data=A; rd_en then pops, giving level=0.
- Wrap-around: stream 3*DEPTH+1 items with random rd_en -> output equals input order, and level never exceeds 4 or underflows.
- Flush: level=3, flush=1 together with push and rd_en -> next cycle level=0, rd_valid=0, in_allowin=1. With PIPE_SINK_STATS_EN, the stat counters read 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the pipeline sink FIFO.
package pipe_pkg;

    localparam int unsigned DEF_WIDTH = 100;
    localparam int unsigned STAT_W    = 32;

    // Ceiling log2 usable in parameter expressions; returns 0 for value <= 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned v;
        result = 0;
        v      = (value > 0) ? value - 1 : 0;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/pipe_sink_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
module pipe_sink_mem
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    // Storage is intentionally not reset; validity is tracked by the owner's count.
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/pipe_sink_fifo.sv
// Receiving end of a valid/allowin pipeline with a show-ahead FIFO read port.
// Define PIPE_SINK_STATS_EN to add saturating accepted/stall counters.
module pipe_sink_fifo
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  in_data,
    output logic              in_allowin,
    input  logic              rd_en,
    output logic              rd_valid,
    output logic [WIDTH-1:0]  rd_data,
    output logic [AW:0]       level
`ifdef PIPE_SINK_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_accepted,
    output logic [STAT_W-1:0] stat_stall
`endif
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;

    logic          w_push;
    logic          w_pop;
    logic          w_wr_en;
    logic [AW:0]   w_count_nxt;

    // Handshake outputs depend only on registered occupancy.
    assign in_allowin = (r_count != FULL_CNT);
    assign rd_valid   = (r_count != '0);
    assign level      = r_count;

    assign w_push  = in_valid && in_allowin;
    assign w_pop   = rd_en && rd_valid;
    assign w_wr_en = w_push && !flush;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + (AW+1)'(1);
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_count <= w_count_nxt;
        end
    end

    pipe_sink_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wptr),
        .i_wr_data (in_data),
        .i_rd_addr (r_rptr),
        .o_rd_data (rd_data)
    );

`ifdef PIPE_SINK_STATS_EN
    logic [STAT_W-1:0] r_stat_accepted;
    logic [STAT_W-1:0] r_stat_stall;
    logic              w_stall;

    assign w_stall = in_valid && !in_allowin;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_accepted <= '0;
            r_stat_stall    <= '0;
        end else if (flush) begin
            r_stat_accepted <= '0;
            r_stat_stall    <= '0;
        end else begin
            if (w_push && (r_stat_accepted != '1)) begin
                r_stat_accepted <= r_stat_accepted + STAT_W'(1);
            end
            if (w_stall && (r_stat_stall != '1)) begin
                r_stat_stall <= r_stat_stall + STAT_W'(1);
            end
        end
    end

    assign stat_accepted = r_stat_accepted;
    assign stat_stall    = r_stat_stall;
`endif

endmodule

// File: tb/tb_pipe_sink_fifo.sv
// Directed bench for pipe_sink_fifo (DEPTH=4, WIDTH=100) with a queue model for the wrap test.
module tb_pipe_sink_fifo;

    localparam int unsigned WIDTH = 100;
    localparam int unsigned DEPTH = 4;

    logic             clk;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_allowin;
    logic             rd_en;
    logic             rd_valid;
    logic [WIDTH-1:0] rd_data;
    logic [2:0]       level;
`ifdef PIPE_SINK_STATS_EN
    logic [31:0]      stat_accepted;
    logic [31:0]      stat_stall;
`endif

    int n_cmp;
    int n_fail;

    pipe_sink_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_allowin (in_allowin),
        .rd_en      (rd_en),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .level      (level)
`ifdef PIPE_SINK_STATS_EN
        ,
        .stat_accepted (stat_accepted),
        .stat_stall    (stat_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [127:0] q[$];
        int           sent;
        int           rcvd;
        int           cycles;
        bit           m_push;
        bit           m_pop;

        n_cmp    = 0;
        n_fail   = 0;
        rst      = 1'b1;
        flush    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        rd_en    = 1'b0;
        step();
        step();
        rst = 1'b0;

        check("reset_level", level, 0);
        check("reset_rd_valid", rd_valid, 0);
        check("reset_allowin", in_allowin, 1);

        // Reset mid-stream
        in_valid = 1'b1;
        in_data = 'h11; step();
        in_data = 'h22; step();
        in_data = 'h33; step();
        in_valid = 1'b0;
        check("pre_rst_level", level, 3);
        check("pre_rst_head", rd_data, 'h11);
        #2 rst = 1'b1;
        #1;
        check("async_rst_level", level, 0);
        check("async_rst_rd_valid", rd_valid, 0);
        check("async_rst_allowin", in_allowin, 1);
        #1 rst = 1'b0;
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        check("post_rst_level", level, 0);
        check("post_rst_rd_valid", rd_valid, 0);

        // Fill and backpressure
        in_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_data = WIDTH'(i);
            step();
        end
        in_data = 'd5;
        step();
        check("fill_level", level, 4);
        check("fill_allowin", in_allowin, 0);
        check("fill_head", rd_data, 1);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        check("bp_pop_level", level, 3);
        check("bp_pop_allowin", in_allowin, 1);
        check("bp_pop_head", rd_data, 2);
        step();
        in_valid = 1'b0;
        check("bp_accept5_level", level, 4);
        check("bp_accept5_allowin", in_allowin, 0);
        rd_en = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            check("bp_drain_data", rd_data, i);
            step();
        end
        rd_en = 1'b0;
        check("bp_drain_level", level, 0);
        check("bp_drain_rd_valid", rd_valid, 0);
`ifdef PIPE_SINK_STATS_EN
        check("stat_accepted_fill", stat_accepted, 5);
        check("stat_stall_fill", stat_stall, 2);
`endif

        // Simultaneous push/pop at steady state
        in_valid = 1'b1;
        in_data = 'h100; step();
        in_data = 'h101; step();
        check("steady_start_level", level, 2);
        rd_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = WIDTH'('h102 + i);
            check("steady_rd_valid", rd_valid, 1);
            check("steady_data", rd_data, 'h100 + i);
            step();
            check("steady_level", level, 2);
        end
        in_valid = 1'b0;
        check("steady_tail0", rd_data, 'h10a);
        step();
        check("steady_tail1", rd_data, 'h10b);
        step();
        rd_en = 1'b0;
        check("steady_empty", level, 0);

        // Empty corner: no bypass
        in_valid = 1'b1;
        in_data  = 'hA;
        rd_en    = 1'b1;
        step();
        in_valid = 1'b0;
        check("empty_push_level", level, 1);
        check("empty_push_rd_valid", rd_valid, 1);
        check("empty_push_data", rd_data, 'hA);
        step();
        rd_en = 1'b0;
        check("empty_pop_level", level, 0);
        check("empty_pop_rd_valid", rd_valid, 0);

        // Wrap-around with random consumer
        sent   = 0;
        rcvd   = 0;
        cycles = 0;
        while (rcvd < 3 * DEPTH + 1 && cycles < 300) begin
            in_valid = (sent < 3 * DEPTH + 1);
            in_data  = WIDTH'('h500 + sent);
            rd_en    = ($urandom_range(0, 2) == 0);
            check("wrap_allowin", in_allowin, (q.size() != DEPTH));
            check("wrap_rd_valid", rd_valid, (q.size() != 0));
            if (q.size() != 0) check("wrap_data", rd_data, q[0]);
            m_push = in_valid && (q.size() != DEPTH);
            m_pop  = rd_en && (q.size() != 0);
            step();
            if (m_pop) begin
                void'(q.pop_front());
                rcvd++;
            end
            if (m_push) begin
                q.push_back(128'('h500 + sent));
                sent++;
            end
            check("wrap_level", level, q.size());
            cycles++;
        end
        in_valid = 1'b0;
        rd_en    = 1'b0;
        check("wrap_all_received", rcvd, 3 * DEPTH + 1);

        // Flush overrides push and pop
        in_valid = 1'b1;
        in_data = 'h61; step();
        in_data = 'h62; step();
        in_data = 'h63; step();
        check("preflush_level", level, 3);
        in_data = 'h64;
        rd_en   = 1'b1;
        flush   = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        rd_en    = 1'b0;
        check("flush_level", level, 0);
        check("flush_rd_valid", rd_valid, 0);
        check("flush_allowin", in_allowin, 1);
`ifdef PIPE_SINK_STATS_EN
        check("flush_stat_accepted", stat_accepted, 0);
        check("flush_stat_stall", stat_stall, 0);
`endif
        in_valid = 1'b1;
        in_data  = 'h77;
        step();
        in_valid = 1'b0;
        check("postflush_level", level, 1);
        check("postflush_data", rd_data, 'h77);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
